// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/VGA memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_CPU = 3'd1,
    ISSUE_VGA = 3'd2,
    DONE_CPU  = 3'd3,
    DONE_VGA  = 3'd4
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VGA = 1'b1
  } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    grant
);

  // bit 0 is the CPU, bit 1 is the VGA port
  always_comb begin
    grant = REQ_CPU;
    case (req)
      2'b01:   grant = REQ_CPU;
      2'b10:   grant = REQ_VGA;
      2'b11:   grant = (last == REQ_CPU) ? REQ_VGA : REQ_CPU;
      default: grant = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle RAM port between a CPU data port and a VGA read port.
// Each access is issue -> done -> idle, so acks arrive two cycles after the request is sampled.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W/8-1:0] cpu_sel,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_stall,
  input  logic                vga_req,
  input  logic [ADDR_W-1:0]   vga_addr,
  output logic [DATA_W-1:0]   vga_rdata,
  output logic                vga_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t  state;
  state_t  state_nx;
  req_id_t last_grant;
  req_id_t grant;

  rr_arb2 u_rr (
    .req   ({vga_req, cpu_req}),
    .last  (last_grant),
    .grant (grant)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cpu_req || vga_req) begin
          state_nx = (grant == REQ_CPU) ? ISSUE_CPU : ISSUE_VGA;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE_CPU: state_nx = DONE_CPU;
      ISSUE_VGA: state_nx = DONE_VGA;
      DONE_CPU:  state_nx = IDLE;
      DONE_VGA:  state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // RAM command is loaded on entry to an issue state; read data and acks on leaving it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_VGA;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_sel    <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      vga_ack    <= 1'b0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      vga_ack <= 1'b0;

      if (state_nx == ISSUE_CPU) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_sel   <= cpu_sel;
        mem_wdata <= cpu_wdata;
      end else if (state_nx == ISSUE_VGA) begin
        mem_en    <= 1'b1;
        mem_addr  <= vga_addr;
        mem_sel   <= '1;
        mem_wdata <= '0;
      end

      if (state == ISSUE_CPU) begin
        cpu_ack   <= 1'b1;
        cpu_rdata <= mem_rdata;
      end else if (state == ISSUE_VGA) begin
        vga_ack   <= 1'b1;
        vga_rdata <= mem_rdata;
      end

      if (state == DONE_CPU) begin
        last_grant <= REQ_CPU;
      end else if (state == DONE_VGA) begin
        last_grant <= REQ_VGA;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [SW-1:0] cpu_sel = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_rdata;
  logic          vga_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Environment RAM: combinational read, byte-masked write on the clock edge
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < SW; b++)
        if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = ram[mem_addr[7:2]];

  // Reference model: each granted access occupies three cycles (issue, ack, rest)
  int            m_busy;
  bit            m_cpu, m_last_vga, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] shadow [64];
  logic [DW-1:0] word;
  logic          e_mem_en, e_mem_we, e_cpu_ack, e_vga_ack;
  logic [AW-1:0] e_mem_addr;
  logic [SW-1:0] e_mem_sel;
  logic [DW-1:0] e_mem_wdata, e_cpu_rdata, e_vga_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_last_vga = 1'b1; m_cpu = 1'b0; m_we = 1'b0;
      e_mem_en = 0; e_mem_we = 0; e_cpu_ack = 0; e_vga_ack = 0;
      e_mem_addr = '0; e_mem_sel = '0; e_mem_wdata = '0; e_cpu_rdata = '0; e_vga_rdata = '0;
      for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    end else begin
      e_mem_en = 0; e_mem_we = 0; e_cpu_ack = 0; e_vga_ack = 0;
      if (m_busy == 0) begin
        if (cpu_req || vga_req) begin
          m_cpu       = cpu_req && (!vga_req || m_last_vga);
          m_we        = m_cpu && cpu_we;
          m_addr      = m_cpu ? cpu_addr : vga_addr;
          e_mem_en    = 1;
          e_mem_we    = m_we;
          e_mem_addr  = m_addr;
          e_mem_sel   = m_cpu ? cpu_sel : 4'hF;
          e_mem_wdata = m_cpu ? cpu_wdata : 32'h0;
          m_busy      = 2;
        end
      end else if (m_busy == 2) begin
        word = shadow[m_addr[7:2]];
        if (m_cpu) begin e_cpu_ack = 1; e_cpu_rdata = word; end
        else       begin e_vga_ack = 1; e_vga_rdata = word; end
        if (m_we)
          for (int b = 0; b < SW; b++)
            if (e_mem_sel[b]) shadow[m_addr[7:2]][8*b +: 8] = e_mem_wdata[8*b +: 8];
        m_busy = 1;
      end else begin
        m_last_vga = !m_cpu;
        m_busy     = 0;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    chk("mem_en", mem_en, e_mem_en);
    chk("mem_we", mem_we, e_mem_we);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_sel", mem_sel, e_mem_sel);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("cpu_ack", cpu_ack, e_cpu_ack);
    chk("vga_ack", vga_ack, e_vga_ack);
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("vga_rdata", vga_rdata, e_vga_rdata);
    chk("cpu_stall", cpu_stall, cpu_req & ~e_cpu_ack);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int          cnt_en, cnt_ack, n_g;
  logic [3:0]  g_seq;
  logic [3:0]  want_seq;

  initial begin
    // reset then idle
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cnt_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en) cnt_en++;
    end
    chk("idle_mem_en_cycles", 64'(cnt_en), 64'd0);
    chk("idle_cpu_rdata", cpu_rdata, 64'h0);
    chk("idle_mem_addr", mem_addr, 64'h0);
    chk("idle_acks", {cpu_ack, vga_ack}, 64'h0);

    // tie straight after reset: C, V, C, V
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_sel = 4'hF;
    vga_req = 1'b1; vga_addr = 32'h30;
    n_g = 0; g_seq = 4'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cpu_ack || vga_ack) begin
        if (n_g < 4) g_seq[n_g] = vga_ack;
        n_g++;
      end
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    want_seq = 4'b1010;
    chk("tie_grant_count", 64'(n_g), 64'd4);
    chk("tie_grant_order", g_seq, want_seq);
    repeat (2) step();

    // CPU read of 0x40
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_sel = 4'hF;
    #1 chk("rd_stall_c0", cpu_stall, 64'h1);
    step();
    chk("rd_mem_en_c1", mem_en, 64'h1);
    chk("rd_mem_addr_c1", mem_addr, 64'h40);
    chk("rd_stall_c1", cpu_stall, 64'h1);
    step();
    chk("rd_ack_c2", cpu_ack, 64'h1);
    chk("rd_data_c2", cpu_rdata, 64'hDEADBEEF);
    chk("rd_stall_c2", cpu_stall, 64'h0);
    cpu_req = 1'b0;
    repeat (2) step();

    // CPU write to 0x80
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_sel = 4'b0011; cpu_wdata = 32'h12345678;
    step();
    chk("wr_mem_we", mem_we, 64'h1);
    chk("wr_mem_sel", mem_sel, 64'h3);
    chk("wr_mem_wdata", mem_wdata, 64'h12345678);
    chk("wr_mem_addr", mem_addr, 64'h80);
    step();
    chk("wr_ack", cpu_ack, 64'h1);
    chk("wr_mem_we_after", mem_we, 64'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) step();

    // request dropped right after grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cnt_en = 0; cnt_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) cpu_req = 1'b0;
      if (mem_en) cnt_en++;
      if (cpu_ack) cnt_ack++;
    end
    chk("drop_issue_count", 64'(cnt_en), 64'd1);
    chk("drop_ack_count", 64'(cnt_ack), 64'd1);

    // reset during a VGA issue
    vga_req = 1'b1; vga_addr = 32'h44;
    step();
    chk("mrst_issue", mem_en, 64'h1);
    rst = 1'b1; vga_req = 1'b0;
    #1 chk("mrst_mem_en_now", mem_en, 64'h0);
    cnt_ack = 0; cnt_en = 0;
    repeat (2) begin step(); if (vga_ack) cnt_ack++; end
    rst = 1'b0;
    repeat (4) begin step(); if (vga_ack) cnt_ack++; if (mem_en) cnt_en++; end
    chk("mrst_no_ack", 64'(cnt_ack), 64'd0);
    chk("mrst_no_issue", 64'(cnt_en), 64'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step();
      if (cpu_req) begin
        if (cpu_ack) begin
          if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
        end else if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom_range(0, 255); cpu_sel = 4'($urandom); cpu_wdata = $urandom;
      end
      if (vga_req) begin
        if (vga_ack) begin
          if ($urandom_range(0, 1) == 0) vga_req = 1'b0;
        end else if ($urandom_range(0, 15) == 0) vga_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        vga_req = 1'b1; vga_addr = $urandom_range(0, 255);
      end
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
